// File: rtl/mux_serializer.sv
// mux_serializer: shifts a 16-bit word out one bit per beat by stepping the
// select of an external 16:1 mux, waiting BIT_CYCLES settle cycles per bit.
module mux_serializer #(
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mux_in,
    output logic [3:0]  mux_sel,
    input  logic        mux_out,
    output logic        ser_bit,
    output logic        ser_valid,
    input  logic        ser_ready,
    output logic        ser_first,
    output logic        ser_last,
    output logic [7:0]  frame_cnt,
    output logic        dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_MAX  = 4'(BIT_CYCLES - 1);
    localparam logic [3:0] SEL_START = MSB_FIRST ? 4'd15 : 4'd0;

    state_t     state;
    logic [3:0] bit_idx;
    logic [3:0] hold_cnt;
    logic       ready_en;
    logic       load;
    logic       xfer;

    // Handshakes: a word/bit moves on a rising edge where valid & ready are
    // both high; ser_valid never depends on ser_ready, and once raised the
    // bit and mux_sel stay stable until the sink takes it.
    assign in_ready  = ready_en & (state == IDLE) & ~flush;
    assign load      = in_valid & in_ready;
    assign ser_valid = (state == SHIFT) & (hold_cnt == HOLD_MAX);
    assign xfer      = ser_valid & ser_ready;
    assign ser_bit   = mux_out;
    assign ser_first = ser_valid & (bit_idx == 4'd0);
    assign ser_last  = ser_valid & (bit_idx == 4'd15);
    assign dbg_state = (state == SHIFT);

    // ready_en keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mux_in    <= 16'd0;
            mux_sel   <= 4'd0;
            bit_idx   <= 4'd0;
            hold_cnt  <= 4'd0;
            frame_cnt <= 8'd0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                state    <= IDLE;
                bit_idx  <= 4'd0;
                hold_cnt <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            mux_in   <= in_data;
                            mux_sel  <= SEL_START;
                            bit_idx  <= 4'd0;
                            hold_cnt <= 4'd0;
                            state    <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (xfer) begin
                            hold_cnt <= 4'd0;
                            if (bit_idx == 4'd15) begin
                                // mux_in and mux_sel are left on the last bit
                                state     <= IDLE;
                                frame_cnt <= frame_cnt + 8'd1;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                                mux_sel <= MSB_FIRST ? (mux_sel - 4'd1) : (mux_sel + 4'd1);
                            end
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_serializer.sv
// Bench for mux_serializer: three instances (LSB-first, MSB-first, 3 settle
// cycles) checked every cycle against a frame-level model plus directed frames.
module tb_mux_serializer;

    localparam int ND = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush     [ND];
    logic        in_valid  [ND];
    logic        ser_ready [ND];
    logic [15:0] in_data   [ND];
    logic        in_ready  [ND];
    logic [15:0] mux_in    [ND];
    logic [3:0]  mux_sel   [ND];
    logic        mux_out   [ND];
    logic        ser_bit   [ND];
    logic        ser_valid [ND];
    logic        ser_first [ND];
    logic        ser_last  [ND];
    logic [7:0]  frame_cnt [ND];
    logic        dbg_state [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mux_serializer #(
            .BIT_CYCLES (g == 2 ? 3 : 1),
            .MSB_FIRST  (g == 1)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[g]),
            .in_data   (in_data[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .mux_in    (mux_in[g]),
            .mux_sel   (mux_sel[g]),
            .mux_out   (mux_out[g]),
            .ser_bit   (ser_bit[g]),
            .ser_valid (ser_valid[g]),
            .ser_ready (ser_ready[g]),
            .ser_first (ser_first[g]),
            .ser_last  (ser_last[g]),
            .frame_cnt (frame_cnt[g]),
            .dbg_state (dbg_state[g])
        );
        // external 16:1 mux
        assign mux_out[g] = mux_in[g][mux_sel[g]];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic int bc_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic int sel_of(input int d, input int b);
        return (d == 1) ? (15 - b) : b;
    endfunction

    // Frame-level model: which bit of which word is current, and how long it has waited.
    int          m_busy   [ND];
    int          m_bit    [ND];
    int          m_wait   [ND];
    int          m_frames [ND];
    logic [15:0] m_word   [ND];
    bit          m_fresh  [ND];
    bit          m_rdy_en [ND];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                m_busy[d]   <= 0;
                m_bit[d]    <= 0;
                m_wait[d]   <= 0;
                m_frames[d] <= 0;
                m_word[d]   <= 16'd0;
                m_fresh[d]  <= 1'b1;
                m_rdy_en[d] <= 1'b0;
            end else begin
                m_rdy_en[d] <= 1'b1;
                if (flush[d]) begin
                    m_busy[d] <= 0;
                end else if (m_busy[d] == 0) begin
                    if (in_valid[d] && m_rdy_en[d]) begin
                        m_busy[d]  <= 1;
                        m_word[d]  <= in_data[d];
                        m_bit[d]   <= 0;
                        m_wait[d]  <= 0;
                        m_fresh[d] <= 1'b0;
                    end
                end else if (m_wait[d] >= bc_of(d) - 1 && ser_ready[d]) begin
                    if (m_bit[d] == 15) begin
                        m_busy[d]   <= 0;
                        m_frames[d] <= m_frames[d] + 1;
                    end else begin
                        m_bit[d]  <= m_bit[d] + 1;
                        m_wait[d] <= 0;
                    end
                end else begin
                    m_wait[d] <= m_wait[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            logic ev;
            int   es;
            ev = (m_busy[d] != 0) && (m_wait[d] >= bc_of(d) - 1);
            es = m_fresh[d] ? 0 : sel_of(d, m_bit[d]);
            check("in_ready", d, in_ready[d], rst_n && m_rdy_en[d] && m_busy[d] == 0 && !flush[d]);
            check("ser_valid", d, ser_valid[d], ev);
            check("ser_first", d, ser_first[d], ev && m_bit[d] == 0);
            check("ser_last", d, ser_last[d], ev && m_bit[d] == 15);
            check("mux_in", d, mux_in[d], m_word[d]);
            check("mux_sel", d, mux_sel[d], es);
            check("frame_cnt", d, frame_cnt[d], m_frames[d] % 256);
            check("dbg_state", d, dbg_state[d], m_busy[d] != 0);
            if (ev) check("ser_bit", d, ser_bit[d], m_word[d][es]);
        end
    end

    logic [3:0] obs_sel [16];

    // Loads one word into dut d and follows it bit by bit. stall_at: bit where
    // ser_ready drops for 5 cycles; abort_at: bit where the frame is aborted
    // by flush (abort_rst = 0) or by reset (abort_rst = 1); -1 disables.
    task automatic run_frame(input int d, input logic [15:0] data, input int stall_at,
                             input int abort_at, input bit abort_rst,
                             output logic [15:0] got, output int cyc,
                             output int first_pos, output int last_pos);
        int n, nbits, stall_left;
        bit done, stalled, rdy;
        ser_ready[d] = 1'b1;
        n = 0;
        @(negedge clk); #1;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("load_ready", d, in_ready[d], 1);
        in_data[d]  = data;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_data[d]  = ~data;
        got = 16'd0; cyc = 0; nbits = 0; first_pos = -1; last_pos = -1;
        stall_left = 0; stalled = 1'b0; done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            rdy = 1'b1;
            if (stall_left > 0) begin
                // only the LSB-first instance is stalled, so sel equals the bit index
                check("stall_sel", d, mux_sel[d], 32'(stall_at));
                check("stall_valid", d, ser_valid[d], 1);
                stall_left--;
                rdy = (stall_left == 0);
            end else if (stall_at >= 0 && !stalled && ser_valid[d] && nbits == stall_at) begin
                stalled    = 1'b1;
                stall_left = 5;
                rdy        = 1'b0;
            end
            ser_ready[d] = rdy;
            if (abort_at >= 0 && ser_valid[d] && nbits == abort_at) begin
                done = 1'b1;
                #1;
                if (abort_rst) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_valid", d, ser_valid[d], 0);
                    check("rst_first", d, ser_first[d], 0);
                    check("rst_last", d, ser_last[d], 0);
                    check("rst_ready", d, in_ready[d], 0);
                    check("rst_mux_in", d, mux_in[d], 0);
                    check("rst_mux_sel", d, mux_sel[d], 0);
                    check("rst_frame_cnt", d, frame_cnt[d], 0);
                    repeat (2) @(posedge clk);
                    @(negedge clk); #1;
                    rst_n = 1'b1;
                    #1 check("rel_ready_low", d, in_ready[d], 0);
                    @(negedge clk); #1;
                    check("rel_ready_high", d, in_ready[d], 1);
                end else begin
                    flush[d] = 1'b1;
                    @(posedge clk); #1;
                    flush[d] = 1'b0;
                    @(negedge clk); #1;
                end
            end else if (ser_valid[d] && rdy) begin
                if (ser_first[d]) first_pos = nbits;
                if (ser_last[d]) last_pos = nbits;
                got[nbits]     = ser_bit[d];
                obs_sel[nbits] = mux_sel[d];
                nbits++;
                if (nbits == 16) begin
                    done = 1'b1;
                    @(negedge clk); #1;
                end
            end
        end
        if (!done) check("frame_timeout", d, 0, 1);
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic [15:0] got;
        int cyc, fp, lp;
        int exp_a [16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
        for (int d = 0; d < ND; d++) begin
            flush[d] = 1'b0; in_valid[d] = 1'b0; ser_ready[d] = 1'b1; in_data[d] = 16'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("reset_ready", d, in_ready[d], 0);
            check("reset_valid", d, ser_valid[d], 0);
            check("reset_mux_in", d, mux_in[d], 0);
            check("reset_mux_sel", d, mux_sel[d], 0);
            check("reset_frame_cnt", d, frame_cnt[d], 0);
        end
        #1 rst_n = 1'b1;
        #1 check("release_ready_low", 0, in_ready[0], 0);
        @(negedge clk);
        check("release_ready_high", 0, in_ready[0], 1);

        // basic LSB-first frame
        run_frame(0, 16'hA5C3, -1, -1, 1'b0, got, cyc, fp, lp);
        for (int i = 0; i < 16; i++) check("a5c3_bit", 0, got[i], exp_a[i]);
        check("a5c3_cycles", 0, cyc, 16);
        check("a5c3_first_pos", 0, fp, 0);
        check("a5c3_last_pos", 0, lp, 15);
        check("a5c3_frame_cnt", 0, frame_cnt[0], 1);
        check("a5c3_idle_ready", 0, in_ready[0], 1);

        // MSB-first frame
        run_frame(1, 16'h8001, -1, -1, 1'b0, got, cyc, fp, lp);
        check("msb_bits", 1, got, 16'b1000_0000_0000_0001);
        for (int i = 0; i < 16; i++) check("msb_sel", 1, obs_sel[i], 15 - i);
        check("msb_cycles", 1, cyc, 16);
        check("msb_frame_cnt", 1, frame_cnt[1], 1);

        // BIT_CYCLES = 3 with a 5-cycle stall at bit 4
        run_frame(2, 16'h5A3C, 4, -1, 1'b0, got, cyc, fp, lp);
        check("bp_bits", 2, got, 16'h5A3C);
        check("bp_cycles", 2, cyc, 53);
        check("bp_frame_cnt", 2, frame_cnt[2], 1);

        // flush at bit 7, then a clean frame
        run_frame(0, 16'hFFFF, -1, 7, 1'b0, got, cyc, fp, lp);
        check("flush_ready", 0, in_ready[0], 1);
        check("flush_valid", 0, ser_valid[0], 0);
        check("flush_frame_cnt", 0, frame_cnt[0], 1);
        @(negedge clk);
        check("flush_valid_next", 0, ser_valid[0], 0);
        run_frame(0, 16'h0F0F, -1, -1, 1'b0, got, cyc, fp, lp);
        check("post_flush_bits", 0, got, 16'h0F0F);
        check("post_flush_first", 0, fp, 0);
        check("post_flush_frame_cnt", 0, frame_cnt[0], 2);

        // frame counter wrap: 256 completed frames in total
        for (int i = 0; i < 253; i++) run_frame(0, 16'(i * 257), -1, -1, 1'b0, got, cyc, fp, lp);
        check("wrap_255", 0, frame_cnt[0], 255);
        run_frame(0, 16'h1234, -1, -1, 1'b0, got, cyc, fp, lp);
        check("wrap_0", 0, frame_cnt[0], 0);

        // reset at bit 9, then a clean frame
        run_frame(0, 16'h7E81, -1, 9, 1'b1, got, cyc, fp, lp);
        run_frame(0, 16'hC35A, -1, -1, 1'b0, got, cyc, fp, lp);
        check("post_rst_bits", 0, got, 16'hC35A);
        check("post_rst_cycles", 0, cyc, 16);
        check("post_rst_frame_cnt", 0, frame_cnt[0], 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_serializer.md
MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 1, meaning settle cycles per bit before the bit is offered (legal 1..15).
REQ-002 SHALL have parameter MSB_FIRST, default 0, meaning 0 = bit 0 first (sel 0→15) and 1 = bit 15 first (sel 15→0).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous abort of the current frame.
REQ-006 SHALL have port in_data, input, 16, the parallel word to serialize.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data is offered.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-009 SHALL have port mux_in, output, 16, the registered word that drives the downstream 16:1 mux data bus.
REQ-010 SHALL have port mux_sel, output, 4, the registered select that drives the 16:1 mux.
REQ-011 SHALL have port mux_out, input, 1, the combinational result returned by the 16:1 mux.
REQ-012 SHALL have port ser_bit, output, 1, the serial data bit, equal to mux_out.
REQ-013 SHALL have port ser_valid, output, 1, meaning ser_bit is offered.
REQ-014 SHALL have port ser_ready, input, 1, meaning the sink accepts ser_bit.
REQ-015 SHALL have port ser_first, output, 1, marking the first bit of a frame.
REQ-016 SHALL have port ser_last, output, 1, marking the last bit of a frame.
REQ-017 SHALL have port frame_cnt, output, 8, the count of completed frames, which wraps.

Function
REQ-018 SHALL implement the FSM states IDLE and SHIFT.
REQ-019 SHALL assert in_ready = 1 only in IDLE with flush = 0.
REQ-020 SHALL, on in_valid & in_ready at edge k, load mux_in <= in_data, set mux_sel to the start index (0, or 15 if MSB_FIRST), set the bit index to 0, clear hold_cnt, and enter SHIFT.
REQ-021 SHALL, in SHIFT, increment hold_cnt each cycle, saturating at BIT_CYCLES-1.
REQ-022 SHALL assert ser_valid only in SHIFT with hold_cnt == BIT_CYCLES-1; with BIT_CYCLES = 1 the first ser_valid is at cycle k+1.
REQ-023 SHALL define a transfer as ser_valid & ser_ready; on a transfer, mux_sel steps ±1, the bit index increments, and hold_cnt clears to 0.
REQ-024 SHALL, while ser_valid & !ser_ready, hold ser_valid, ser_bit, mux_sel and hold_cnt stable.
REQ-025 SHALL drive ser_first = ser_valid & (bit index == 0) and ser_last = ser_valid & (bit index == 15).
REQ-026 SHALL, on the ser_last transfer, return to IDLE, increment frame_cnt modulo 256 (255→0), and hold mux_in unchanged.
REQ-027 SHALL give a minimum frame time of 16*BIT_CYCLES cycles, with at least 1 IDLE cycle between frames; there is no back-to-back load.
REQ-028 SHALL, when flush = 1, go to IDLE at the next edge from any state, drop the frame with no ser_valid in the following cycle, and leave frame_cnt unincremented.
REQ-029 SHALL give flush priority over a simultaneous load or ser_last transfer; that word is not accepted and frame_cnt does not increment.
REQ-030 SHALL ignore in_valid in SHIFT; in_data may change freely because mux_in is registered.
REQ-031 SHALL sample mux_out combinationally with no extra register stage; the settle time is covered by BIT_CYCLES.

Reset
REQ-032 SHALL, while rst_n = 0, asynchronously force state IDLE, mux_in = 0, mux_sel = 0, bit index = 0, hold_cnt = 0, and frame_cnt = 0.
REQ-033 SHALL hold ser_valid = ser_first = ser_last = 0 and in_ready = 0 during reset, with in_ready = 1 at the first edge after rst_n rises.
REQ-034 SHALL abandon a frame without output when rst_n asserts mid-frame.

Verification
REQ-035 SHALL cover the basic frame: BIT_CYCLES = 1, MSB_FIRST = 0, in_data = 16'hA5C3, ser_ready = 1 → ser_bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 consecutive cycles, ser_first on bit 0, ser_last on bit 15, and frame_cnt 0→1.
REQ-036 SHALL cover MSB_FIRST = 1 with in_data = 16'h8001 → mux_sel runs 15..0, and ser_bit reads 1, then fourteen 0s, then 1.
REQ-037 SHALL cover backpressure: BIT_CYCLES = 3 with ser_ready low for 5 cycles at bit 4 → mux_sel stays 4 and ser_valid stays high; resume gives a frame of 48 + 5 cycles.
REQ-038 SHALL cover flush at bit 7 → IDLE the next cycle, in_ready = 1, no ser_valid, frame_cnt unchanged; a following word serializes from bit 0.
REQ-039 SHALL cover wrap: 256 completed frames → frame_cnt returns to 0.
REQ-040 SHALL cover reset mid-frame: rst_n low at bit 9 → all outputs at reset values immediately, and a new frame starts cleanly afterwards.
